apb_master_arbiter: RTL and testbench

Shares one APB master port between `NUM_REQ` on-chip requesters. It round-robin arbitrates simple request/response channels and sequences the APB SETUP/ACCESS phases. It honours slave wait states and bounds them with a timeout. It drives the master-side signals of `apb_interface` (`PSEL`, `PENABLE`, `PADDR`, `PWRITE`, `PWDATA`, `PSTRB`, `PPROT`) and samples `PREADY`, `PRDATA` and `PSLVERR`.

---
 rtl/apb_master_arbiter_pkg.sv | 21 ++
 rtl/apb_master_arbiter_if.sv | 28 ++
 rtl/apb_master_arbiter_rr.sv | 39 +++
 rtl/apb_master_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM states, default widths
// and round-robin pointer arithmetic.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Requester that gets top priority after requester idx has been served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle; the arbiter drives it through the master modport.
interface apb_interface
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_W-1:0]     PADDR;
  logic                  PWRITE;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  PPROT;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: searches from i_ptr upward and reports the
// winner, a one-hot grant gated by i_en, and the pointer to use after that grant.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic                 i_en,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_ptr
);
  localparam int PW = $clog2(N);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    o_ptr   = i_ptr;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = PW'(w_cand);
      end
    end
    if (o_valid && i_en) begin
      o_grant[o_idx] = 1'b1;
      o_ptr          = PW'(rr_next(int'(o_idx), N));
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, wait-state timeout and registered per-requester responses.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           PCLOCK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]  req_strb,
  input  logic [NUM_REQ-1:0]             req_prot,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  apb_interface.master                   apb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PW     = $clog2(NUM_REQ);
  localparam int CW     = $clog2(TIMEOUT);

  apb_state_e          r_state;
  apb_state_e          w_state_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_cur;
  logic [PW-1:0]       w_gidx;
  logic [PW-1:0]       w_ptr_next;
  logic                w_any;
  logic                w_grant_en;
  logic                w_take;
  logic                w_done;
  logic                w_timeout;
  logic [CW-1:0]       r_tcnt;

  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic                r_pprot;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  // A transfer ends on PREADY, or when the wait counter has run out with PREADY still low.
  assign w_timeout  = (r_state == ACCESS) && !apb.PREADY && (r_tcnt == CW'(TIMEOUT - 1));
  assign w_done     = (r_state == ACCESS) && (apb.PREADY || w_timeout);
  assign w_grant_en = (r_state == IDLE) || w_done;
  assign w_take     = w_grant_en && w_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_grant_en),
    .o_grant (req_ready),
    .o_idx   (w_gidx),
    .o_valid (w_any),
    .o_ptr   (w_ptr_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_done) w_state_next = w_take ? SETUP : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLOCK) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (r_state != ACCESS) r_tcnt <= '0;
      else if (!apb.PREADY)  r_tcnt <= r_tcnt + CW'(1);
    end
  end

  // Bus fields are latched at grant so requesters may move on the following cycle.
  always_ff @(posedge PCLOCK) begin
    if (!PRESETn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pprot   <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_cur     <= '0;
    end else begin
      r_psel    <= (w_state_next != IDLE);
      r_penable <= (w_state_next == ACCESS);
      if (w_take) begin
        r_cur    <= w_gidx;
        r_paddr  <= req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
        r_pwrite <= req_write[w_gidx];
        r_pprot  <= req_prot[w_gidx];
        if (req_write[w_gidx]) begin
          r_pwdata <= req_wdata[int'(w_gidx)*DATA_W +: DATA_W];
          r_pstrb  <= req_strb[int'(w_gidx)*STRB_W +: STRB_W];
        end else begin
          r_pstrb  <= '0;
        end
      end
    end
  end

  always_ff @(posedge PCLOCK) begin
    if (!PRESETn) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid <= NUM_REQ'(1) << r_cur;
        r_rsp_err   <= w_timeout | apb.PSLVERR;
        r_rsp_rdata <= (w_timeout || r_pwrite) ? '0 : apb.PRDATA;
      end
    end
  end

  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PPROT   = r_pprot;
  assign apb.PADDR   = r_paddr;
  assign apb.PWDATA  = r_pwdata;
  assign apb.PSTRB   = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: the bench plays both requesters and the APB slave.
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 16;

  logic                          PCLOCK = 1'b0;
  logic                          PRESETn;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*DATA_W-1:0]     req_wdata;
  logic [NUM_REQ*STRB_W-1:0]     req_strb;
  logic [NUM_REQ-1:0]            req_prot;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          rsp_err;

  int errors = 0;
  int checks = 0;

  apb_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLOCK    (PCLOCK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 PCLOCK = ~PCLOCK;

  task automatic tick();
    @(posedge PCLOCK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn     = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_strb    = '0;
    req_prot    = '0;
    apb.PREADY  = 1'b0;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    tick();
    tick();
    checks++;
    if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PPROT} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PPROT});
    end
    checks++;
    if ({apb.PADDR, apb.PWDATA, apb.PSTRB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_fields: addr %h wdata %h strb %h want all 0", apb.PADDR, apb.PWDATA, apb.PSTRB);
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: valid %b rdata %h err %b want all 0", rsp_valid, rsp_rdata, rsp_err);
    end
    PRESETn = 1'b1;
    tick();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_idle_ready: got %b want 00", req_ready);
    end
  endtask

  task automatic test_single_read();
    req_addr[15:0] = 16'h0010;
    req_write      = 2'b00;
    req_prot       = 2'b01;
    req_valid      = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rd_grant: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({apb.PSEL, apb.PENABLE} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rd_setup: sel/en %b want 10", {apb.PSEL, apb.PENABLE});
    end
    checks++;
    if ({apb.PADDR, apb.PWRITE, apb.PPROT, apb.PSTRB} !== {16'h0010, 1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("[TB] FAIL rd_fields: addr %h wr %b prot %b strb %h want 0010 0 1 0",
               apb.PADDR, apb.PWRITE, apb.PPROT, apb.PSTRB);
    end
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'hDEADBEEF;
    tick();
    checks++;
    if ({apb.PSEL, apb.PENABLE, rsp_valid} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL rd_access: sel/en/rsp %b want 1100", {apb.PSEL, apb.PENABLE, rsp_valid});
    end
    tick();
    apb.PREADY = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, apb.PSEL} !== {2'b01, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rd_rsp: valid %b rdata %h err %b sel %b want 01 deadbeef 0 0",
               rsp_valid, rsp_rdata, rsp_err, apb.PSEL);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL rd_hold: valid %b rdata %h want 00 deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write_wait();
    req_addr[31:16]  = 16'h0A04;
    req_wdata[63:32] = 32'h12345678;
    req_strb[7:4]    = 4'h3;
    req_write        = 2'b10;
    req_prot         = 2'b00;
    req_valid        = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wr_grant: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_no_grant_in_setup: got %b want 00", req_ready);
    end
    req_valid = 2'b00;
    checks++;
    if ({apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB} !== {16'h0A04, 1'b1, 32'h12345678, 4'h3}) begin
      errors++;
      $display("[TB] FAIL wr_fields: addr %h wr %b wdata %h strb %h want 0a04 1 12345678 3",
               apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({apb.PENABLE, apb.PSTRB, rsp_valid} !== {1'b1, 4'h3, 2'b00}) begin
        errors++;
        $display("[TB] FAIL wr_wait_%0d: en %b strb %h rsp %b want 1 3 00", i, apb.PENABLE, apb.PSTRB, rsp_valid);
      end
      if (i == 3) apb.PREADY = 1'b1;
      tick();
    end
    apb.PREADY = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb.PENABLE} !== {2'b10, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wr_rsp: valid %b err %b rdata %h en %b want 10 0 0 0",
               rsp_valid, rsp_err, rsp_rdata, apb.PENABLE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int          rem [2];
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rsp;
    logic [15:0] exp_addr;
    rem[0]    = 4;
    rem[1]    = 4;
    exp_addr  = '0;
    req_write = 2'b00;
    apb.PREADY = 1'b1;
    for (int c = 0; c < 18; c++) begin
      apb.PRDATA = 32'hA000_0000 + c;
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = (rem[i] > 0);
        req_addr[i*ADDR_W +: ADDR_W] = 16'h0100 + 16'(i*16 + rem[i]);
      end
      #1;
      exp_ready = (c % 2 == 0 && c <= 14) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp   = (c % 2 == 1 && c >= 3) ? ((((c - 3) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL b2b_grant c%0d: got %b want %b", c, req_ready, exp_ready);
      end
      checks++;
      if ({apb.PSEL, apb.PENABLE} !== {(c >= 1 && c <= 16), (c >= 2 && c <= 16 && c % 2 == 0)}) begin
        errors++;
        $display("[TB] FAIL b2b_phase c%0d: sel/en %b%b", c, apb.PSEL, apb.PENABLE);
      end
      if (c % 2 == 1 && c <= 15) begin
        checks++;
        if (apb.PADDR !== exp_addr) begin
          errors++;
          $display("[TB] FAIL b2b_addr c%0d: got %h want %h", c, apb.PADDR, exp_addr);
        end
      end
      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++;
        $display("[TB] FAIL b2b_rsp c%0d: got %b want %b", c, rsp_valid, exp_rsp);
      end
      if (exp_rsp != 2'b00) begin
        checks++;
        if (rsp_rdata !== 32'hA000_0000 + 32'(c - 1)) begin
          errors++;
          $display("[TB] FAIL b2b_rdata c%0d: got %h want %h", c, rsp_rdata, 32'hA000_0000 + 32'(c - 1));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (exp_ready[i]) begin
          exp_addr = req_addr[i*ADDR_W +: ADDR_W];
          rem[i]--;
        end
      end
      tick();
    end
    req_valid  = 2'b00;
    apb.PREADY = 1'b0;
  endtask

  task automatic test_timeout();
    req_addr[15:0] = 16'h0020;
    req_write      = 2'b00;
    apb.PREADY     = 1'b0;
    apb.PRDATA     = 32'hFFFF_FFFF;
    for (int c = 0; c < 19; c++) begin
      req_valid = (c == 0) ? 2'b01 : 2'b00;
      #1;
      if (c == 0) begin
        checks++;
        if (req_ready !== 2'b01) begin
          errors++;
          $display("[TB] FAIL to_grant: got %b want 01", req_ready);
        end
      end
      checks++;
      if ({apb.PSEL, apb.PENABLE} !== {(c >= 1 && c <= 17), (c >= 2 && c <= 17)}) begin
        errors++;
        $display("[TB] FAIL to_phase c%0d: sel/en %b%b", c, apb.PSEL, apb.PENABLE);
      end
      checks++;
      if (rsp_valid !== ((c == 18) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL to_rsp c%0d: got %b", c, rsp_valid);
      end
      if (c == 18) begin
        checks++;
        if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
          errors++;
          $display("[TB] FAIL to_err: err %b rdata %h want 1 0", rsp_err, rsp_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_slverr();
    logic [1:0]  onehot;
    logic [31:0] rdata;
    for (int t = 0; t < 2; t++) begin
      onehot = (t == 0) ? 2'b10 : 2'b01;
      rdata  = (t == 0) ? 32'hCAFE_F00D : 32'h55AA_55AA;
      req_addr  = {16'h0B00, 16'h0C00};
      req_write = 2'b00;
      req_valid = onehot;
      #1;
      checks++;
      if (req_ready !== onehot) begin
        errors++;
        $display("[TB] FAIL se_grant t%0d: got %b want %b", t, req_ready, onehot);
      end
      tick();
      req_valid   = 2'b00;
      apb.PREADY  = 1'b1;
      apb.PSLVERR = (t == 0);
      apb.PRDATA  = rdata;
      tick();
      tick();
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {onehot, (t == 0), rdata}) begin
        errors++;
        $display("[TB] FAIL se_rsp t%0d: valid %b err %b rdata %h want %b %b %h",
                 t, rsp_valid, rsp_err, rsp_rdata, onehot, (t == 0), rdata);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req_addr   = {16'h0031, 16'h0030};
    req_write  = 2'b00;
    req_valid  = 2'b11;
    apb.PREADY = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rm_grant_pre: got %b want 10", req_ready);
    end
    tick();
    tick();
    checks++;
    if (apb.PENABLE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_access: en %b want 1", apb.PENABLE);
    end
    PRESETn = 1'b0;
    tick();
    checks++;
    if ({apb.PSEL, apb.PENABLE, rsp_valid, rsp_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL rm_cleared: sel %b en %b rsp %b rdata %h want all 0",
               apb.PSEL, apb.PENABLE, rsp_valid, rsp_rdata);
    end
    PRESETn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rm_grant_post: got %b want 01", req_ready);
    end
    tick();
    req_valid  = 2'b00;
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h0BAD_F00D;
    checks++;
    if ({apb.PSEL, apb.PADDR, rsp_valid} !== {1'b1, 16'h0030, 2'b00}) begin
      errors++;
      $display("[TB] FAIL rm_setup: sel %b addr %h rsp %b want 1 0030 00", apb.PSEL, apb.PADDR, rsp_valid);
    end
    tick();
    tick();
    apb.PREADY = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h0BAD_F00D}) begin
      errors++;
      $display("[TB] FAIL rm_rsp: valid %b rdata %h want 01 0badf00d", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
